// File: rtl/rat_io_hub.sv
`default_nettype none
// ============================================================================
// Module   : rat_io_hub
// Purpose  : I/O hub between the RAT MCU and the board I/O. It provides:
//            - an MCU clock-enable divider (MCU_CE, one CLK wide, every DIV);
//            - N_IN input ports, each passed through a two-flop synchroniser
//              and read back through a combinational PORT_ID read mux;
//            - N_OUT output registers written on MCU_CE & IO_STRB;
//            - a debounced button that raises a latched interrupt (INTR),
//              cleared by a write to ACK_ID.
// Ports    : CLK      in   system clock
//            RST_N    in   asynchronous active-low reset
//            MCU_CE   out  MCU clock enable
//            PORT_ID  in   MCU port address (8 bits)
//            OUT_PORT in   MCU write data (WIDTH)
//            IO_STRB  in   MCU write strobe
//            IN_PORT  out  MCU read data (WIDTH)
//            IN_DATA  in   external inputs, port k = [k*WIDTH +: WIDTH]
//            OUT_DATA out  output registers, reg k = [k*WIDTH +: WIDTH]
//            BTN      in   raw asynchronous button
//            INTR     out  level interrupt, held until acknowledged
// Config   : RAT_IO_READBACK_EN - when defined, IN_PORT also returns the
//            output registers at OUT_BASE+k and {0.., pending} at ACK_ID.
// Revision : 1.0 - initial release
// ============================================================================
module rat_io_hub #(
  parameter int         WIDTH    = 8,
  parameter int         N_IN     = 4,
  parameter int         N_OUT    = 4,
  parameter logic [7:0] IN_BASE  = 8'h20,
  parameter logic [7:0] OUT_BASE = 8'h40,
  parameter logic [7:0] ACK_ID   = 8'hF0,
  parameter int         DIV      = 2,
  parameter int         DEB_CYC  = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  output logic                   MCU_CE,
  input  logic [7:0]             PORT_ID,
  input  logic [WIDTH-1:0]       OUT_PORT,
  input  logic                   IO_STRB,
  output logic [WIDTH-1:0]       IN_PORT,
  input  logic [N_IN*WIDTH-1:0]  IN_DATA,
  output logic [N_OUT*WIDTH-1:0] OUT_DATA,
  input  logic                   BTN,
  output logic                   INTR
);

  // Divider counter needs at least one bit even when DIV==1.
  localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);

  // DEB_CYC-1 always fits in clog2(DEB_CYC) bits for DEB_CYC >= 2.
  localparam int c_deb_w = $clog2(DEB_CYC);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    ST_LO      = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HI      = 2'd2,
    ST_WAIT_LO = 2'd3
  } deb_state_t;

  logic [c_div_w-1:0]      r_div_cnt;
  logic                    r_mcu_ce;
  logic                    w_wr;

  logic [N_IN*WIDTH-1:0]   r_in_s1;
  logic [N_IN*WIDTH-1:0]   r_in_s2;
  logic                    r_btn_s1;
  logic                    r_btn_s2;

  logic [WIDTH-1:0]        r_regs [N_OUT];
  logic [WIDTH-1:0]        w_rd;

  deb_state_t              r_deb_state;
  deb_state_t              w_deb_state_nx;
  logic [c_deb_w-1:0]      r_deb_cnt;
  logic [c_deb_w-1:0]      w_deb_cnt_nx;
  logic                    w_rise;
  logic                    r_rise;
  logic                    r_pending;

  // --------------------------------------------------------------------------
  // MCU clock-enable divider. MCU_CE is registered so it is high during the
  // cycle that follows count==DIV-1.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_mcu_ce  <= 1'b0;
    end else if (r_div_cnt == c_div_last) begin
      r_div_cnt <= '0;
      r_mcu_ce  <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
      r_mcu_ce  <= 1'b0;
    end
  end

  assign MCU_CE = r_mcu_ce;

  // One write per MCU cycle: the strobe only counts while the enable is high.
  assign w_wr = r_mcu_ce & IO_STRB;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers for every external input bit and the button.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_in_s1  <= '0;
      r_in_s2  <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_in_s1  <= IN_DATA;
      r_in_s2  <= r_in_s1;
      r_btn_s1 <= BTN;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_wr && (PORT_ID == 8'(OUT_BASE + k))) begin
          r_regs[k] <= OUT_PORT;
        end
      end
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < N_OUT; gk++) begin : g_out_pack
      assign OUT_DATA[gk*WIDTH +: WIDTH] = r_regs[gk];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Combinational read mux. Unmapped IDs read as zero.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (PORT_ID == 8'(IN_BASE + k)) begin
        w_rd = r_in_s2[k*WIDTH +: WIDTH];
      end
    end
`ifdef RAT_IO_READBACK_EN
    for (int k = 0; k < N_OUT; k++) begin
      if (PORT_ID == 8'(OUT_BASE + k)) begin
        w_rd = r_regs[k];
      end
    end
    if (PORT_ID == ACK_ID) begin
      w_rd = WIDTH'(r_pending);
    end
`endif
  end

  assign IN_PORT = w_rd;

  // --------------------------------------------------------------------------
  // Button debounce. A level change is accepted only after DEB_CYC
  // consecutive samples at the new level; any bounce back restarts from the
  // old stable state. Only an accepted press produces an event.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb_state <= ST_LO;
      r_deb_cnt   <= '0;
      r_rise      <= 1'b0;
    end else begin
      r_deb_state <= w_deb_state_nx;
      r_deb_cnt   <= w_deb_cnt_nx;
      r_rise      <= w_rise;
    end
  end

  always_comb begin
    w_deb_state_nx = r_deb_state;
    w_deb_cnt_nx   = r_deb_cnt;
    w_rise         = 1'b0;
    case (r_deb_state)
      ST_LO: begin
        if (r_btn_s2) begin
          w_deb_state_nx = ST_WAIT_HI;
          w_deb_cnt_nx   = c_deb_w'(1);
        end
      end
      ST_WAIT_HI: begin
        if (!r_btn_s2) begin
          w_deb_state_nx = ST_LO;
          w_deb_cnt_nx   = '0;
        end else if (r_deb_cnt == c_deb_last) begin
          w_deb_state_nx = ST_HI;
          w_deb_cnt_nx   = '0;
          w_rise         = 1'b1;
        end else begin
          w_deb_cnt_nx   = r_deb_cnt + 1'b1;
        end
      end
      ST_HI: begin
        if (!r_btn_s2) begin
          w_deb_state_nx = ST_WAIT_LO;
          w_deb_cnt_nx   = c_deb_w'(1);
        end
      end
      ST_WAIT_LO: begin
        if (r_btn_s2) begin
          w_deb_state_nx = ST_HI;
          w_deb_cnt_nx   = '0;
        end else if (r_deb_cnt == c_deb_last) begin
          w_deb_state_nx = ST_LO;
          w_deb_cnt_nx   = '0;
        end else begin
          w_deb_cnt_nx   = r_deb_cnt + 1'b1;
        end
      end
      default: begin
        w_deb_state_nx = ST_LO;
        w_deb_cnt_nx   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Interrupt latch. A press event takes priority over a same-cycle
  // acknowledge so that no press is ever lost; repeated presses merge.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= 1'b0;
    end else if (r_rise) begin
      r_pending <= 1'b1;
    end else if (w_wr && (PORT_ID == ACK_ID)) begin
      r_pending <= 1'b0;
    end
  end

  assign INTR = r_pending;

endmodule
`default_nettype wire
